// File: rtl/cursor_box_plotter.sv
// Renders the board pointer as a square outline on the VGA adapter pixel port:
// erases the previously drawn cell in background colour, then draws the new one.
module cursor_box_plotter #(
  parameter int unsigned CELL          = 7,
  parameter int unsigned ORIGIN_X      = 24,
  parameter int unsigned ORIGIN_Y      = 4,
  parameter logic [2:0]  CURSOR_COLOUR = 3'b100,
  parameter logic [2:0]  BG_COLOUR     = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] x_co,
  input  logic [3:0] y_co,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  localparam int unsigned CW = (CELL > 1) ? $clog2(CELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(CELL - 1);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW} state_t;

  state_t        state;
  logic [3:0]    x_s1, x_s2, y_s1, y_s2;
  logic [3:0]    drawn_x, drawn_y, target_x, target_y;
  logic [CW-1:0] dx, dy;

  logic [3:0]    cell_x, cell_y;
  logic [7:0]    px, py;
  logic          border, pass_end;
  logic [2:0]    pcol;

  // Pixel address and attributes for the current (dx,dy) of the active pass
  always_comb begin
    cell_x   = (state == DRAW) ? target_x : drawn_x;
    cell_y   = (state == DRAW) ? target_y : drawn_y;
    px       = 8'(ORIGIN_X) + 8'(cell_x) * 8'(CELL) + 8'(dx);
    py       = 8'(ORIGIN_Y) + 8'(cell_y) * 8'(CELL) + 8'(dy);
    border   = (dx == '0) || (dx == LAST) || (dy == '0) || (dy == LAST);
    pass_end = (dx == LAST) && (dy == LAST);
    pcol     = (state == DRAW) ? CURSOR_COLOUR : BG_COLOUR;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_s1     <= '0;
      x_s2     <= '0;
      y_s1     <= '0;
      y_s2     <= '0;
      drawn_x  <= '0;
      drawn_y  <= '0;
      target_x <= '0;
      target_y <= '0;
      dx       <= '0;
      dy       <= '0;
      state    <= DRAW;
      vga_x    <= '0;
      vga_y    <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      busy     <= 1'b1;
    end else begin
      x_s1 <= x_co;
      x_s2 <= x_s1;
      y_s1 <= y_co;
      y_s2 <= y_s1;
      case (state)
        IDLE: begin
          plot <= 1'b0;
          busy <= 1'b0;
          if ((x_s2 != drawn_x) || (y_s2 != drawn_y)) begin
            target_x <= x_s2;
            target_y <= y_s2;
            dx       <= '0;
            dy       <= '0;
            state    <= ERASE;
            busy     <= 1'b1;
          end
        end
        ERASE, DRAW: begin
          plot   <= border;
          vga_x  <= px;
          vga_y  <= py[6:0];
          colour <= pcol;
          busy   <= 1'b1;
          if (pass_end) begin
            dx <= '0;
            dy <= '0;
            if (state == ERASE) begin
              state <= DRAW;
            end else begin
              drawn_x <= target_x;
              drawn_y <= target_y;
              state   <= IDLE;
            end
          end else if (dx == LAST) begin
            dx <= '0;
            dy <= dy + CW'(1);
          end else begin
            dx <= dx + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_box_plotter.sv
// Directed bench for cursor_box_plotter: expected pixels are queued when a move
// is driven and popped by a monitor as the DUT strobes plot.
module tb_cursor_box_plotter;

  localparam int C  = 7;
  localparam int OX = 24;
  localparam int OY = 4;
  localparam logic [2:0] CUR = 3'b100;
  localparam logic [2:0] BG  = 3'b000;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] x_co, y_co;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot, busy;

  int passed = 0;
  int total  = 0;
  int cyc = 0;
  int t0 = 0;
  int first_plot = -1;
  int last_plot = -1;
  int busy_cycles = 0;
  int mx = 0;
  int my = 0;
  logic [17:0] sb[$];

  cursor_box_plotter dut (
    .clk(clk), .resetn(resetn), .x_co(x_co), .y_co(y_co),
    .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected border pixels of one pass in walk order (dx inner, dy outer)
  task automatic push_pass(input int cx, input int cy, input logic [2:0] col);
    for (int j = 0; j < C; j++)
      for (int i = 0; i < C; i++)
        if (i == 0 || i == C - 1 || j == 0 || j == C - 1)
          sb.push_back({8'(OX + cx * C + i), 7'(OY + cy * C + j), col});
  endtask

  task automatic mark();
    first_plot  = -1;
    last_plot   = -1;
    busy_cycles = 0;
    t0          = cyc;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit seen = 0;
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
      else if (seen) done = 1;
    end
    #1;
    check({tag, "_idle"}, 32'(done), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_plot"},   32'(plot),   32'd0);
    check({tag, "_vga_x"},  32'(vga_x),  32'd0);
    check({tag, "_vga_y"},  32'(vga_y),  32'd0);
    check({tag, "_colour"}, 32'(colour), 32'd0);
    check({tag, "_busy"},   32'(busy),   32'd1);
  endtask

  task automatic move(input string tag, input int nx, input int ny);
    push_pass(mx, my, BG);
    push_pass(nx, ny, CUR);
    @(negedge clk); #1;
    mark();
    x_co = 4'(nx);
    y_co = 4'(ny);
    wait_idle(tag, 300);
    check({tag, "_first"}, 32'(first_plot - t0), 32'd4);
    check({tag, "_busy_len"}, 32'(busy_cycles), 32'd99);
    check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    mx = nx;
    my = ny;
  endtask

  // Monitor: pops the scoreboard on each plotted pixel
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (resetn === 1'b1) begin
        if (busy) busy_cycles++;
        if (plot) begin
          if (first_plot < 0) first_plot = cyc;
          last_plot = cyc;
          check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("pixel", 32'({vga_x, vga_y, colour}), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    resetn = 1'b0;
    x_co   = 4'd0;
    y_co   = 4'd0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");

    // Release: single draw at (0,0), no erase
    push_pass(0, 0, CUR);
    mark();
    resetn = 1'b1;
    wait_idle("release", 200);
    check("release_first", 32'(first_plot - t0), 32'd1);
    check("release_last", 32'(last_plot - t0), 32'd49);
    check("release_busy_len", 32'(busy_cycles), 32'd49);
    check("release_sb_empty", 32'(sb.size()), 32'd0);

    move("x0to1", 1, 0);
    move("to15_15", 15, 15);
    move("wrap_x", 0, 15);

    // Changes during the draw pass are ignored; final value equals drawn
    push_pass(0, 15, BG);
    push_pass(0, 0, CUR);
    @(negedge clk); #1;
    mark();
    y_co = 4'd0;
    repeat (60) @(negedge clk);
    y_co = 4'd3;
    repeat (5) @(negedge clk);
    y_co = 4'd5;
    repeat (5) @(negedge clk);
    y_co = 4'd0;
    wait_idle("glitch", 300);
    repeat (20) @(negedge clk);
    #1;
    check("glitch_busy_len", 32'(busy_cycles), 32'd99);
    check("glitch_busy_low", 32'(busy), 32'd0);
    check("glitch_sb_empty", 32'(sb.size()), 32'd0);
    mx = 0;
    my = 0;

    move("y0to5", 0, 5);

    // Reset in the middle of an erase pass
    push_pass(mx, my, BG);
    @(negedge clk); #1;
    mark();
    x_co = 4'd4;
    repeat (20) @(negedge clk);
    #1;
    check("mid_first", 32'(first_plot - t0), 32'd4);
    resetn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    sb.delete();
    x_co = 4'd0;
    y_co = 4'd0;
    repeat (3) @(negedge clk);
    #1;
    push_pass(0, 0, CUR);
    mark();
    resetn = 1'b1;
    wait_idle("rerelease", 200);
    check("rerelease_first", 32'(first_plot - t0), 32'd1);
    check("rerelease_busy_len", 32'(busy_cycles), 32'd49);
    check("rerelease_sb_empty", 32'(sb.size()), 32'd0);
    mx = 0;
    my = 0;

    move("diag", 2, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cursor_box_plotter.md
# cursor_box_plotter

Consumes the 4-bit board pointer coordinates (x, y in 0..15) produced by the coordinate generators and renders the pointer as a square outline on the 160x120 VGA adapter pixel-write port. On every pointer change it erases the outline at the previously drawn cell in background colour, then draws the outline at the new cell. It sits between the coordinate generators and the VGA adapter, sharing the adapter's pixel clock.

## Interface
- CELL, 7: cell pitch and outline size in pixels.
- ORIGIN_X, 24: screen x of cell column 0.
- ORIGIN_Y, 4: screen y of cell row 0.
- CURSOR_COLOUR, 3'b100: outline colour.
- BG_COLOUR, 3'b000: erase colour.

- clk  in  1  pixel-domain clock; all state on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- x_co  in  4  pointer column; asynchronous to clk.
- y_co  in  4  pointer row; asynchronous to clk.
- vga_x  out  8  pixel x to the adapter.
- vga_y  out  7  pixel y to the adapter.
- colour  out  3  pixel colour.
- plot  out  1  pixel write strobe, one pixel per high cycle.
- busy  out  1  high while an erase or draw pass is in progress or its last pixel is still on the port.

## Operation
- Input sync: x_co and y_co each pass through a two-flop synchronizer; reset value 0. Only synced values are used.
- Registers: drawn (x,y), the cell currently on screen; target (x,y), the cell being drawn; dx, dy pass counters in 0..CELL-1.
- States: IDLE, ERASE, DRAW.
- IDLE: if synced coords differ from drawn, latch synced coords into target, clear dx/dy, go to ERASE. Otherwise stay.
- ERASE: walks all CELL*CELL offsets at the drawn cell in BG_COLOUR. At dx=dy=CELL-1, clear dx/dy and go to DRAW.
- DRAW: same walk at the target cell in CURSOR_COLOUR. At dx=dy=CELL-1, copy target into drawn and go to IDLE.
- Walk order: dx increments each cycle; on dx wrap from CELL-1 to 0, dy increments.
- Plot only border pixels: dx==0, dx==CELL-1, dy==0 or dy==CELL-1. That is 4*(CELL-1)=24 writes per pass at default.
- Address calculation: vga_x = ORIGIN_X + cell_x*CELL + dx, and vga_y = ORIGIN_Y + cell_y*CELL + dy.
- Address width: compute unsigned at 8 bits; vga_y takes the low 7 bits.
- Range: defaults keep the maximum at x=135 and y=115, so no clipping is performed.
- Coordinate wrap: 15 to 0 is an ordinary change; the erase at column 15 is followed by the draw at column 0.
- Changes during ERASE/DRAW are ignored. Back in IDLE, the latest synced value is compared against drawn, so intermediate values are never drawn and a final value equal to drawn causes no pass.
- Simultaneous x and y change produces one erase/draw pair.
- Reset state: DRAW with drawn=target=(0,0) and dx=dy=0. After release, the outline is drawn at (0,0) with no erase pass. The top level clears the screen on reset.
- Reset mid-pass: immediate abort; outputs return to reset values.

## Timing
- Reset values: plot=0, vga_x=0, vga_y=0, colour=0, busy=1.
- Output register: vga_x, vga_y, colour and plot are registered from the counter state, so each pixel appears one cycle after its (dx,dy) cycle.
- busy = (state != IDLE) | plot.
- Pass length: exactly CELL*CELL clocks (49 at default), including non-plotted interior cycles.
- Change latency: a coordinate change stable at the input reaches the synced value 2 clocks later. IDLE detects it on the next clock, and ERASE's first pixel is on the port 1 clock after that.
- Full move: 2*CELL*CELL clocks from ERASE entry to IDLE.
- Last pixel: the final DRAW pixel is on the port during the first IDLE cycle; busy falls the cycle after.
- A new change may be accepted in that first IDLE cycle.

## Test plan
- Reset release, x_co=y_co=0: 24 plots in CURSOR_COLOUR covering the border of x 24..30, y 4..10. First plot (24,4) one clock after release; last plot (30,10) 49 clocks after release; busy low the next clock; no BG_COLOUR writes.
- x_co 0 to 1 from IDLE: 24 BG writes on the x 24..30 border, then 24 CURSOR writes on the x 31..37 border (y 4..10). busy high 98 clocks plus the trailing pixel.
- Wrap, x_co 15 to 0 with y_co=15: erase covers x 129..135, y 109..115; draw covers x 24..30, y 109..115.
- y_co 0 to 3 to 5 to 0 while DRAW is in progress: the current pass completes and no further pass follows. Then y_co 0 to 5 in IDLE gives exactly one erase/draw pair ending at y 39..45.
- resetn low mid-ERASE: plot, vga_x, vga_y and colour are 0 immediately and busy=1. After release, one DRAW pass at (0,0) with no erase.
- x_co and y_co change on the same clock, (0,0) to (2,3): a single pair of passes, erase at (0,0) then draw at x 38..44, y 25..31.
